// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST response analyzer.
// Holds the FSM state enum, SISR width/taps and the SISR feedback helper.
package bist_pkg;

    localparam int SIG_W = 8;

    // x^8 + x^4 + x^3 + x^2 + 1, taps on sig[7], sig[3], sig[2], sig[1]
    localparam logic [SIG_W-1:0] SISR_TAPS = 8'h8E;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_e;

    function automatic logic sisr_fb(
        input logic [SIG_W-1:0] sig,
        input logic             din
    );
        return (^(sig & SISR_TAPS)) ^ din;
    endfunction

endpackage

// File: rtl/bist_sisr.sv
// Serial-input signature register compacting the scan response stream.
// Ports: clk, rst_n (async, active-low), clr (sync clear), en (shift), din (serial in), sig (contents).
module bist_sisr
    import bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], sisr_fb(sig_q, din)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST output-side controller: sequences scan_en, compacts scan_out, compares against GOLDEN.
// Ports: clk, rst_n, start, scan_out in; scan_en, busy, done, pass, signature[7:0] out.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int               CHAIN_LEN    = 8,
    parameter int               NUM_PATTERNS = 16,
    parameter logic [SIG_W-1:0] GOLDEN       = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             scan_out,
    output logic             scan_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int WW = (NUM_PATTERNS > 0) ? $clog2(NUM_PATTERNS + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(NUM_PATTERNS);

    state_e           state_q;
    logic [BW-1:0]    bit_q;
    logic [WW-1:0]    win_q;
    logic             scan_en_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             cmp_en_q;
    logic             sisr_clr;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] sig_flush;

    assign sisr_clr = start && (state_q == S_IDLE || state_q == S_DONE);

    // FLUSH always follows a shift cycle, so the SISR takes one more bit on the
    // edge leaving FLUSH; compare against that settled value.
    assign sig_flush = {sig[SIG_W-2:0], sisr_fb(sig, scan_out)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_q     <= '0;
            win_q     <= '0;
            scan_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cmp_en_q  <= 1'b0;
        end else begin
            // Matches the output register on the chain's scan_out.
            cmp_en_q <= scan_en_q;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_SHIFT;
                        bit_q     <= '0;
                        win_q     <= '0;
                        scan_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (bit_q == BIT_LAST) begin
                        bit_q     <= '0;
                        scan_en_q <= 1'b0;
                        state_q   <= (win_q < WIN_LAST) ? S_CAPTURE : S_FLUSH;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    win_q     <= win_q + 1'b1;
                    scan_en_q <= 1'b1;
                    state_q   <= S_SHIFT;
                end
                S_FLUSH: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (sig_flush == GOLDEN);
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    bist_sisr u_sisr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sisr_clr),
        .en    (cmp_en_q),
        .din   (scan_out),
        .sig   (sig)
    );

    assign scan_en   = scan_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Self-checking bench for bist_response_analyzer with a schedule/bit-stream reference model.
// Covers reset, zero/random streams, GOLDEN mismatch, short chain, mid-session reset and LFSR integration.
module tb_bist_response_analyzer;

    localparam logic [7:0] CAP_MASK = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] sisr_step(input logic [7:0] s, input logic b);
        return {s[6:0], (^(s & 8'h8E)) ^ b};
    endfunction

    // scan_en schedule: windows of cl shifts separated by one low, np+1 windows.
    function automatic bit en_exp(input int c, input int cl, input int np);
        return (c >= 0) && (c < (np + 1) * (cl + 1) - 1) && ((c % (cl + 1)) < cl);
    endfunction

    // The bit presented during cycle c is absorbed if scan_en was high the cycle before.
    function automatic bit absorbed(input int c, input int cl, input int np);
        return (c >= 1) && en_exp(c - 1, cl, np);
    endfunction

    // Expected signature for LFSR + chain: window 0 unloads zeros, window k
    // unloads the captured image of the k-th LFSR byte.
    function automatic logic [7:0] lfsr_gold();
        logic [7:0] l;
        logic [7:0] s;
        logic [7:0] ld;
        logic [7:0] nx;
        logic [7:0] u;
        l  = 8'hBD;
        s  = 8'h00;
        ld = 8'h00;
        for (int k = 0; k <= 16; k++) begin
            u  = (k == 0) ? 8'h00 : (ld ^ CAP_MASK);
            nx = 8'h00;
            for (int i = 0; i < 8; i++) begin
                s  = sisr_step(s, u[7 - i]);
                nx = {nx[6:0], l[7]};
                l  = {l[6:0], ^(l & LFSR_TAPS)};
            end
            ld = nx;
        end
        return s;
    endfunction

    localparam logic [7:0] GOLD_D = lfsr_gold();

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_d;
    logic start_a, so_a, start_c, so_c, start_d, flip, so_d;
    logic en_a, busy_a, done_a, pass_a;
    logic en_b, busy_b, done_b, pass_b;
    logic en_c, busy_c, done_c, pass_c;
    logic en_d, busy_d, done_d, pass_d;
    logic [7:0] sig_a, sig_b, sig_c, sig_d;

    int n_chk = 0;
    int n_fail = 0;

    bist_response_analyzer u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .scan_out(so_a),
        .scan_en(en_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a)
    );

    bist_response_analyzer #(.GOLDEN(8'h01)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_a), .scan_out(so_a),
        .scan_en(en_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b)
    );

    bist_response_analyzer #(.CHAIN_LEN(4), .NUM_PATTERNS(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .scan_out(so_c),
        .scan_en(en_c), .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c)
    );

    bist_response_analyzer #(.GOLDEN(GOLD_D)) u_d (
        .clk(clk), .rst_n(rst_d), .start(start_d), .scan_out(so_d),
        .scan_en(en_d), .busy(busy_d), .done(done_d), .pass(pass_d), .signature(sig_d)
    );

    // Pattern LFSR and 8-bit scan chain feeding u_d.
    logic [7:0] lfsr_q, chain_q;
    logic so_q;
    always @(posedge clk or negedge rst_d) begin
        if (!rst_d) begin
            lfsr_q  <= 8'hBD;
            chain_q <= 8'h00;
            so_q    <= 1'b0;
        end else begin
            so_q <= chain_q[7];
            if (en_d) begin
                chain_q <= {chain_q[6:0], lfsr_q[7]};
                lfsr_q  <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
            end else if (busy_d) begin
                chain_q <= chain_q ^ CAP_MASK;
            end
        end
    end
    assign so_d = so_q ^ flip;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start_a = 1'($urandom_range(0, 1));
            so_a    = 1'($urandom_range(0, 1));
            start_c = 1'($urandom_range(0, 1));
            so_c    = 1'($urandom_range(0, 1));
            step();
            n_chk++;
            if ({en_a, busy_a, done_a, pass_a, sig_a, en_c, busy_c, done_c, pass_c, sig_c} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold a=%b%b%b%b/%h c=%b%b%b%b/%h required all 0",
                         en_a, busy_a, done_a, pass_a, sig_a, en_c, busy_c, done_c, pass_c, sig_c);
            end
        end
        start_a = 1'b0;
        start_c = 1'b0;
        so_a    = 1'b0;
        so_c    = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++;
            if ({en_a, busy_a, done_a, pass_a, sig_a, en_c, busy_c, done_c, pass_c, sig_c} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle a=%b%b%b%b/%h c=%b%b%b%b/%h required all 0",
                         en_a, busy_a, done_a, pass_a, sig_a, en_c, busy_c, done_c, pass_c, sig_c);
            end
        end
    endtask

    // One default-parameter session on u_a/u_b; optional ignored start pulse
    // while busy and optional start held from the done edge into DONE.
    task automatic run_ab(input bit rnd, input bit poke, input bit early);
        logic       bits [0:159];
        logic [7:0] m;
        m = 8'h00;
        for (int c = 0; c < 160; c++) bits[c] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        start_a = 1'b1;
        so_a    = 1'b0;
        step();
        start_a = 1'b0;
        for (int c = 0; c <= 153; c++) begin
            n_chk++;
            if (en_a !== en_exp(c, 8, 16) || busy_a !== (c < 153) || done_a !== (c == 153)
                || en_b !== en_a || done_b !== done_a) begin
                n_fail++;
                $display("FAIL ctrl c=%0d en/busy/done=%b%b%b b=%b%b required %b%b%b",
                         c, en_a, busy_a, done_a, en_b, done_b,
                         en_exp(c, 8, 16), (c < 153), (c == 153));
            end
            if (c < 153) begin
                so_a = bits[c];
                if (absorbed(c, 8, 16)) m = sisr_step(m, bits[c]);
                start_a = (poke && c == 20) || (early && c == 152);
                step();
            end
        end
        n_chk++;
        if (sig_a !== m || sig_b !== m) begin
            n_fail++;
            $display("FAIL signature a=%h b=%h required %h", sig_a, sig_b, m);
        end
        n_chk++;
        if (pass_a !== (m == 8'h00) || pass_b !== (m == 8'h01)) begin
            n_fail++;
            $display("FAIL pass a=%b b=%b required %b %b", pass_a, pass_b, (m == 8'h00), (m == 8'h01));
        end
        if (early) begin
            step();
            start_a = 1'b0;
            n_chk++;
            if ({en_a, busy_a, done_a, pass_a, sig_a} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
                n_fail++;
                $display("FAIL restart en/busy/done/pass=%b%b%b%b sig=%h required 1100 00",
                         en_a, busy_a, done_a, pass_a, sig_a);
            end
        end
    endtask

    task automatic test_zero_stream();
        run_ab(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random_restart();
        run_ab(1'b1, 1'b1, 1'b1);
    endtask

    // u_a is at cycle 0 of the restarted session; reset it 20 cycles in.
    task automatic test_mid_reset();
        for (int i = 0; i < 20; i++) begin
            so_a = 1'($urandom_range(0, 1));
            step();
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({en_a, busy_a, done_a, pass_a, sig_a} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset en/busy/done/pass=%b%b%b%b sig=%h required 0000 00",
                     en_a, busy_a, done_a, pass_a, sig_a);
        end
        step();
        rst_n = 1'b1;
        so_a  = 1'b0;
        step();
        run_ab(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_short_chain();
        logic [7:0] m;
        m = 8'h00;
        start_c = 1'b1;
        so_c    = 1'b0;
        step();
        start_c = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            n_chk++;
            if (en_c !== en_exp(c, 4, 0) || busy_c !== (c < 5) || done_c !== (c == 5) || sig_c !== m) begin
                n_fail++;
                $display("FAIL short c=%0d en/busy/done=%b%b%b sig=%h required %b%b%b %h",
                         c, en_c, busy_c, done_c, sig_c, en_exp(c, 4, 0), (c < 5), (c == 5), m);
            end
            if (c < 5) begin
                so_c = (c == 1);
                if (absorbed(c, 4, 0)) m = sisr_step(m, so_c);
                step();
            end
        end
        so_c = 1'b0;
        n_chk++;
        if (pass_c !== (m == 8'h00)) begin
            n_fail++;
            $display("FAIL short_pass got %b required %b", pass_c, (m == 8'h00));
        end
    endtask

    task automatic lfsr_session(input int flip_at, output int cyc);
        rst_d = 1'b0;
        step();
        rst_d   = 1'b1;
        start_d = 1'b1;
        step();
        start_d = 1'b0;
        cyc = 0;
        while (!done_d && cyc < 300) begin
            flip = (cyc == flip_at);
            step();
            cyc++;
        end
        flip = 1'b0;
    endtask

    task automatic test_lfsr();
        int cyc;
        lfsr_session(-1, cyc);
        n_chk++;
        if (cyc != 153) begin
            n_fail++;
            $display("FAIL lfsr_len got %0d required 153", cyc);
        end
        n_chk++;
        if (sig_d !== GOLD_D || pass_d !== 1'b1) begin
            n_fail++;
            $display("FAIL lfsr_sig sig=%h pass=%b required %h 1", sig_d, pass_d, GOLD_D);
        end
        lfsr_session(50, cyc);
        n_chk++;
        if (cyc != 153 || pass_d !== 1'b0 || sig_d === GOLD_D) begin
            n_fail++;
            $display("FAIL lfsr_flip len=%0d pass=%b sig=%h required 153 0 not %h", cyc, pass_d, sig_d, GOLD_D);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rst_d   = 1'b0;
        start_a = 1'b0;
        start_c = 1'b0;
        start_d = 1'b0;
        so_a    = 1'b0;
        so_c    = 1'b0;
        flip    = 1'b0;
        test_reset();
        test_zero_stream();
        test_random_restart();
        test_mid_reset();
        test_short_chain();
        test_lfsr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
